// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter_seq interval-timer sequencer.
package counter_seq_pkg;

  // Sequencer state encoding; values match the legacy 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Value loaded into the counter at the start of every period.
  localparam int unsigned CNT_RST_VAL = 0;

endpackage : counter_seq_pkg

// File: rtl/counter_seq_counter.sv
// Loadable up-counter: synchronous reset, load has priority over enable.
module counter_seq_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out
);

  logic [WIDTH-1:0] cnt_q;

  // Count register: reset, then load, then increment when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= cnt_in;
    end else if (enab) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_out = cnt_q;

endmodule : counter_seq_counter

// File: rtl/counter_seq.sv
// Programmable interval timer: captures a period on start, runs the counter
// from 0 to the period, pulses done, then stops or reloads.
module counter_seq
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_rld,
  input  logic [WIDTH-1:0] period,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cnt_out
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             load, enab;
  logic             terminal;

  assign terminal = (cnt_out == period_q);

  // Next-state, capture and counter-control decode.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    load     = 1'b0;
    enab     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          period_d = period;
          mode_d   = auto_rld;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        state_d = stop ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (terminal) begin
          // Terminal handling beats stop: done still pulses, but a stop
          // suppresses the reload and returns to IDLE holding the count.
          done_d = 1'b1;
          if (mode_q && !stop) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (stop) begin
          state_d = ST_IDLE;
        end else begin
          enab = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured run parameters and registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  counter_seq_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .enab    (enab),
    .cnt_in  (WIDTH'(CNT_RST_VAL)),
    .cnt_out (cnt_out)
  );

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule : counter_seq

// File: tb/tb_counter_seq.sv
// Directed, table-driven bench for counter_seq (WIDTH = 5).
module tb_counter_seq;

  localparam int unsigned W = 5;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic         auto_rld;
  logic [W-1:0] period;
  logic         busy;
  logic         done;
  logic [W-1:0] cnt_out;

  int unsigned n_tests;
  int unsigned n_fail;

  typedef struct {
    logic         rst;
    logic         start;
    logic         stop;
    logic         auto_rld;
    logic [W-1:0] period;
    logic         exp_busy;
    logic         exp_done;
    logic [W-1:0] exp_cnt;
    string        name;
  } vec_t;

  vec_t vecs[$];

  counter_seq #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .auto_rld (auto_rld),
    .period   (period),
    .busy     (busy),
    .done     (done),
    .cnt_out  (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string nm, input logic r, input logic s, input logic p,
                     input logic a, input logic [W-1:0] per, input logic eb,
                     input logic ed, input logic [W-1:0] ec);
    vec_t v;
    v.name = nm; v.rst = r; v.start = s; v.stop = p; v.auto_rld = a;
    v.period = per; v.exp_busy = eb; v.exp_done = ed; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic eb, input logic ed,
                           input logic [W-1:0] ec);
    check({nm, ".busy"}, busy, eb);
    check({nm, ".done"}, done, ed);
    check({nm, ".cnt"}, cnt_out, ec);
  endtask

  // Drive inputs #1 after a rising edge, advance one edge, sample #1 later.
  task automatic drive(input logic r, input logic s, input logic p,
                       input logic a, input logic [W-1:0] per);
    rst = r; start = s; stop = p; auto_rld = a; period = per;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);

    //   name        rst st sp ar per  busy done cnt
    add("reset",     1, 0, 0, 0, 0,   0, 0, 0);
    // One-shot P=3
    add("os_start",  0, 1, 0, 0, 3,   1, 0, 0);
    add("os_load",   0, 0, 0, 0, 0,   1, 0, 0);
    add("os_c1",     0, 0, 0, 0, 0,   1, 0, 1);
    add("os_c2",     0, 0, 0, 0, 0,   1, 0, 2);
    add("os_c3",     0, 0, 0, 0, 0,   1, 0, 3);
    add("os_term",   0, 0, 0, 0, 0,   0, 1, 3);
    add("os_idle",   0, 0, 0, 0, 0,   0, 0, 3);
    // Auto-reload P=2, then stop at cnt=1
    add("ar_start",  0, 1, 0, 1, 2,   1, 0, 3);
    add("ar_load",   0, 0, 0, 0, 0,   1, 0, 0);
    add("ar_c1",     0, 0, 0, 0, 0,   1, 0, 1);
    add("ar_c2",     0, 0, 0, 0, 0,   1, 0, 2);
    add("ar_rl0",    0, 0, 0, 0, 0,   1, 1, 0);
    add("ar_c1b",    0, 0, 0, 0, 0,   1, 0, 1);
    add("ar_c2b",    0, 0, 0, 0, 0,   1, 0, 2);
    add("ar_rl0b",   0, 0, 0, 0, 0,   1, 1, 0);
    add("ar_c1c",    0, 0, 0, 0, 0,   1, 0, 1);
    add("ar_stop",   0, 0, 1, 0, 0,   0, 0, 1);
    // Stop mid-run P=10 at cnt=4
    add("sp_start",  0, 1, 0, 0, 10,  1, 0, 1);
    add("sp_load",   0, 0, 0, 0, 0,   1, 0, 0);
    add("sp_c1",     0, 0, 0, 0, 0,   1, 0, 1);
    add("sp_c2",     0, 0, 0, 0, 0,   1, 0, 2);
    add("sp_c3",     0, 0, 0, 0, 0,   1, 0, 3);
    add("sp_c4",     0, 0, 0, 0, 0,   1, 0, 4);
    add("sp_stop",   0, 0, 1, 0, 0,   0, 0, 4);
    add("sp_hold",   0, 0, 0, 0, 0,   0, 0, 4);
    // start+stop together in IDLE: no run
    add("ss_idle",   0, 1, 1, 1, 9,   0, 0, 4);
    add("ss_hold",   0, 0, 0, 0, 0,   0, 0, 4);
    // Stop on the terminal cycle, P=5 auto-reload
    add("ts_start",  0, 1, 0, 1, 5,   1, 0, 4);
    add("ts_load",   0, 0, 0, 0, 0,   1, 0, 0);
    add("ts_c1",     0, 0, 0, 0, 0,   1, 0, 1);
    add("ts_c2",     0, 0, 0, 0, 0,   1, 0, 2);
    add("ts_c3",     0, 0, 0, 0, 0,   1, 0, 3);
    add("ts_c4",     0, 0, 0, 0, 0,   1, 0, 4);
    add("ts_c5",     0, 0, 0, 0, 0,   1, 0, 5);
    add("ts_stop",   0, 0, 1, 0, 0,   0, 1, 5);
    add("ts_idle",   0, 0, 0, 0, 0,   0, 0, 5);
    // P=0 auto-reload: done every cycle after the first RUN cycle
    add("z_start",   0, 1, 0, 1, 0,   1, 0, 5);
    add("z_load",    0, 0, 0, 0, 0,   1, 0, 0);
    add("z_run1",    0, 0, 0, 0, 0,   1, 1, 0);
    add("z_run2",    0, 0, 0, 0, 0,   1, 1, 0);
    add("z_run3",    0, 0, 0, 0, 0,   1, 1, 0);
    add("z_stop",    0, 0, 1, 0, 0,   0, 1, 0);
    add("z_idle",    0, 0, 0, 0, 0,   0, 0, 0);
    // stop while in LOAD: load still applies, back to IDLE
    add("ls_start",  0, 1, 0, 0, 4,   1, 0, 0);
    add("ls_stop",   0, 0, 1, 0, 0,   0, 0, 0);
    add("ls_idle",   0, 0, 0, 0, 0,   0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].auto_rld, vecs[i].period);
      step();
      check_all(vecs[i].name, vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_cnt);
    end

    // P=31 one-shot, with an ignored start (P=3, auto) issued mid-run.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd31);
    step();
    check_all("max_start", 1'b1, 1'b0, 5'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    check_all("max_load", 1'b1, 1'b0, 5'd0);
    for (int i = 1; i <= 31; i++) begin
      if (i == 3) drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd3);
      else        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      step();
      check_all($sformatf("max_c%0d", i), 1'b1, 1'b0, W'(i));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    check_all("max_term", 1'b0, 1'b1, 5'd31);
    step();
    check_all("max_nowrap", 1'b0, 1'b0, 5'd31);

    // Reset for 2 cycles mid-run, P=7 one-shot.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd7);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    step();
    step();
    check_all("rm_pre", 1'b1, 1'b0, 5'd2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step();
    check_all("rm_rst1", 1'b0, 1'b0, 5'd0);
    step();
    check_all("rm_rst2", 1'b0, 1'b0, 5'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    check_all("rm_after", 1'b0, 1'b0, 5'd0);

    // Reset on a terminal cycle must not produce a done pulse.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    check_all("rt_run", 1'b1, 1'b0, 5'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step();
    check_all("rt_rst", 1'b0, 1'b0, 5'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    check_all("rt_idle", 1'b0, 1'b0, 5'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_counter_seq
